writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
// - Write-back stage directly upstream of the regfile: merges results from the single-cycle ALU and
//   multi-cycle units (FPU/mem) onto the regfile's single write port.
// - Buffers multi-cycle results in an in-order FIFO while the ALU owns the port.
// - Keeps a per-register pending scoreboard for issue-stage hazard checks.
// - Outputs are registered on posedge clk, so they are stable for the regfile's negedge write.
// PARAMETERS
// - BUS_WIDTH    64  data width, matches regfile
// - REGFILE_LEN  6   register address width (x0-x31, f0-f31)
// - FIFO_DEPTH   4   multi-cycle result buffer entries, power of 2, >=2
// PORTS
// - clk              in   1            clock, all state on posedge
// - rst_n            in   1            asynchronous active-low reset
// - alu_valid        in   1            ALU result valid; always accepted, no ready
// - alu_addr         in   REGFILE_LEN  ALU destination register
// - alu_data         in   BUS_WIDTH    ALU result
// - mc_valid         in   1            multi-cycle result valid
// - mc_ready         out  1            FIFO can accept; transfer when mc_valid & mc_ready
// - mc_addr          in   REGFILE_LEN  multi-cycle destination register
// - mc_data          in   BUS_WIDTH    multi-cycle result
// - issue_valid      in   1            instruction issued with destination issue_addr
// - issue_addr       in   REGFILE_LEN  destination register to mark pending
// - chk_addr1/2      in   REGFILE_LEN  issue-stage source operands to check
// - chk_busy1/2      out  1            1 = register has an outstanding write
// - wb_write_enable  out  1            to regfile write_enable
// - wb_write_addr    out  REGFILE_LEN  to regfile write_addr
// - wb_write_data    out  BUS_WIDTH    to regfile write_data
// - fifo_count       out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Reset (async, rst_n low): wb_write_enable=0, wb_write_addr=0, wb_write_data=0.
//   FIFO emptied (fifo_count=0) and all pending bits cleared.
//   In-flight entries are discarded. The deassertion of wb_write_enable takes effect immediately, not at the next edge.
// - mc_ready = (fifo_count != FIFO_DEPTH). Combinational. It is 1 during and after reset.
// - Port arbitration each posedge, in fixed priority:
//   (1) ALU, when alu_valid and alu_addr != 0;
//   (2) else FIFO head, which is popped;
//   (3) else nothing, so wb_write_enable=0 next cycle.
// - A multi-cycle result accepted with the FIFO empty and no ALU request is still pushed and popped the next cycle.
//   Latency: ALU 1 cycle; multi-cycle >= 2 cycles. There is no direct bypass, which keeps the path simple and registered.
// - Push and pop in the same cycle are legal when the FIFO is full. mc_ready reflects pre-pop occupancy, so no push happens at full.
// - Entries with destination address 0 are accepted and dropped: the ALU is not granted, the FIFO does not store them,
//   and no write is issued. The regfile write of x0 is therefore never requested.
// - Scoreboard: pending[issue_addr] is set on issue_valid when issue_addr != 0.
//   The pending bit for wb_write_addr is cleared on the edge where the write commits, i.e. the cycle wb_write_enable=1.
//   Same-cycle set and clear on one address: set wins.
// - chk_busyN = pending[chk_addrN]; register 0 always reads 0.
//   A register retiring in the current cycle still reads busy; forwarding is handled downstream of this block.
// - Precondition: at most one outstanding write per register. Issue stalls while the destination is busy.
//   The bench asserts this; a violation is not defined behaviour.
// - FIFO pointers wrap modulo FIFO_DEPTH. The FIFO is strictly in order.
// - Sustained alu_valid starves the FIFO by design. Upstream throttles through mc_ready.
// STRUCTURE
// - Shared package wb_pkg: BUS_WIDTH/REGFILE_LEN constants and the wb_req_t struct {addr, data}.
// - Sub-module wb_fifo (params WIDTH, DEPTH): push/pop/full/empty/count, async active-low reset.
// - Top level: arbiter, output register, pending[2**REGFILE_LEN-1:0] scoreboard.
// TESTING
// - Reset mid-stream: fill FIFO with 3 entries, pulse rst_n low for 3ns between edges ->
//   wb_write_enable=0 immediately, fifo_count=0, chk_busy all 0, mc_ready=1.
// - ALU priority: alu_valid addr=5 data=0xAA and mc_valid addr=7 data=0xBB in the same cycle ->
//   cycle+1 writes x5=0xAA; cycle+2 writes x7=0xBB.
// - Full FIFO: hold alu_valid to x3 for 6 cycles with 5 mc pushes -> mc_ready=0 after the 4th push.
//   After alu_valid drops, entries retire in push order, one per cycle.
// - x0 drop: alu_valid addr=0 with FIFO head addr=9 -> x9 written that cycle.
//   An mc push to addr 0 -> fifo_count unchanged, no write.
// - Scoreboard: issue addr=12 -> chk_busy1 (chk_addr1=12) = 1 until the x12 write commits, then 0 the following cycle.
//   Re-issue addr 12 on the commit cycle -> remains 1.
// - Back-to-back: 8 alternating ALU/mc results to distinct registers -> all 8 written exactly once, data matching.
//   No cycle has wb_write_enable with addr 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: regfile geometry and the buffered
// write request carried through the multi-cycle result FIFO.
package wb_pkg;

   localparam int unsigned BUS_WIDTH   = 64;
   localparam int unsigned REGFILE_LEN = 6;

   typedef struct packed {
      logic [REGFILE_LEN-1:0] addr;
      logic [BUS_WIDTH-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer with occupancy count; DEPTH must be a power of 2 and >= 2
// so that the pointers wrap naturally.
module wb_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic [PW:0]      count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   // Storage needs no reset: reads are gated by the occupancy count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates ALU and buffered multi-cycle results onto the
// single regfile write port and tracks outstanding writes per register.
module writeback_unit #(
   parameter int unsigned BUS_WIDTH   = wb_pkg::BUS_WIDTH,
   parameter int unsigned REGFILE_LEN = wb_pkg::REGFILE_LEN,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        alu_valid,
   input  logic [REGFILE_LEN-1:0]      alu_addr,
   input  logic [BUS_WIDTH-1:0]        alu_data,
   input  logic                        mc_valid,
   output logic                        mc_ready,
   input  logic [REGFILE_LEN-1:0]      mc_addr,
   input  logic [BUS_WIDTH-1:0]        mc_data,
   input  logic                        issue_valid,
   input  logic [REGFILE_LEN-1:0]      issue_addr,
   input  logic [REGFILE_LEN-1:0]      chk_addr1,
   input  logic [REGFILE_LEN-1:0]      chk_addr2,
   output logic                        chk_busy1,
   output logic                        chk_busy2,
   output logic                        wb_write_enable,
   output logic [REGFILE_LEN-1:0]      wb_write_addr,
   output logic [BUS_WIDTH-1:0]        wb_write_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   import wb_pkg::wb_req_t;

   localparam int unsigned NREGS = 2**REGFILE_LEN;

   logic                   alu_grant;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   wb_req_t                mc_req;
   wb_req_t                fifo_head;

   logic                   wb_we_q;
   logic                   wb_we_d;
   logic [REGFILE_LEN-1:0] wb_addr_q;
   logic [REGFILE_LEN-1:0] wb_addr_d;
   logic [BUS_WIDTH-1:0]   wb_data_q;
   logic [BUS_WIDTH-1:0]   wb_data_d;
   logic [NREGS-1:0]       pending_q;
   logic [NREGS-1:0]       pending_d;

   // Requests targeting x0 are consumed but never granted or buffered.
   assign alu_grant = alu_valid && (alu_addr != '0);
   assign mc_ready  = !fifo_full;
   assign fifo_push = mc_valid && mc_ready && (mc_addr != '0);
   assign fifo_pop  = !alu_grant && !fifo_empty;

   always_comb begin
      mc_req.addr = mc_addr;
      mc_req.data = mc_data;
   end

   wb_fifo #(
      .WIDTH ($bits(wb_req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i (mc_req),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      wb_we_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      if (alu_grant) begin
         wb_we_d   = 1'b1;
         wb_addr_d = alu_addr;
         wb_data_d = alu_data;
      end else if (fifo_pop) begin
         wb_we_d   = 1'b1;
         wb_addr_d = fifo_head.addr;
         wb_data_d = fifo_head.data;
      end
   end

   // Clear for the committing write first so a same-cycle re-issue keeps the bit set.
   always_comb begin
      pending_d = pending_q;
      if (wb_we_q) begin
         pending_d[wb_addr_q] = 1'b0;
      end
      if (issue_valid && (issue_addr != '0)) begin
         pending_d[issue_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         pending_q <= '0;
      end else begin
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         pending_q <= pending_d;
      end
   end

   assign chk_busy1 = (chk_addr1 != '0) && pending_q[chk_addr1];
   assign chk_busy2 = (chk_addr2 != '0) && pending_q[chk_addr2];

   assign wb_write_enable = wb_we_q;
   assign wb_write_addr   = wb_addr_q;
   assign wb_write_data   = wb_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on the observed write log.
module tb_writeback_unit;

   localparam int unsigned BW    = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid, mc_valid, issue_valid;
   logic [AW-1:0] alu_addr, mc_addr, issue_addr, chk_addr1, chk_addr2;
   logic [BW-1:0] alu_data, mc_data;
   logic          mc_ready, chk_busy1, chk_busy2, wb_write_enable;
   logic [AW-1:0] wb_write_addr;
   logic [BW-1:0] wb_write_data;
   logic [2:0]    fifo_count;

   always #5 clk = ~clk;

   writeback_unit #(
      .BUS_WIDTH   (BW),
      .REGFILE_LEN (AW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alu_valid       (alu_valid),
      .alu_addr        (alu_addr),
      .alu_data        (alu_data),
      .mc_valid        (mc_valid),
      .mc_ready        (mc_ready),
      .mc_addr         (mc_addr),
      .mc_data         (mc_data),
      .issue_valid     (issue_valid),
      .issue_addr      (issue_addr),
      .chk_addr1       (chk_addr1),
      .chk_addr2       (chk_addr2),
      .chk_busy1       (chk_busy1),
      .chk_busy2       (chk_busy2),
      .wb_write_enable (wb_write_enable),
      .wb_write_addr   (wb_write_addr),
      .wb_write_data   (wb_write_data),
      .fifo_count      (fifo_count)
   );

   typedef struct { logic [AW-1:0] addr; logic [BW-1:0] data; } req_t;
   typedef struct { logic [AW-1:0] addr; logic [BW-1:0] data; int cyc; } wr_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   req_t mq[$];
   wr_t  wlog[$];
   logic          m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [BW-1:0] m_data = '0;
   bit            m_pend [64];

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a plain queue of buffered results and a pending bitmap.
   always @(posedge clk or negedge rst_n) begin : model
      req_t          h;
      bit            ready;
      bit            clr_we;
      logic [AW-1:0] clr_a;
      if (!rst_n) begin
         mq.delete();
         m_we = 1'b0;
         m_addr = '0;
         m_data = '0;
         foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
         ready  = (mq.size() < DEPTH);
         clr_we = m_we;
         clr_a  = m_addr;
         if (alu_valid && alu_addr != 0) begin
            m_we = 1'b1; m_addr = alu_addr; m_data = alu_data;
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = 1'b1; m_addr = h.addr; m_data = h.data;
         end else begin
            m_we = 1'b0;
         end
         if (mc_valid && ready && mc_addr != 0) mq.push_back('{mc_addr, mc_data});
         if (clr_we) m_pend[clr_a] = 1'b0;
         if (issue_valid && issue_addr != 0) begin
            check("issue_precondition", m_pend[issue_addr], 1'b0);
            m_pend[issue_addr] = 1'b1;
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("wb_we", wb_write_enable, m_we);
         if (m_we) begin
            check("wb_addr", wb_write_addr, m_addr);
            check("wb_data", wb_write_data, m_data);
         end
         check("fifo_count", fifo_count, mq.size());
         check("mc_ready", mc_ready, mq.size() < DEPTH);
         check("chk_busy1", chk_busy1, (chk_addr1 != 0) && m_pend[chk_addr1]);
         check("chk_busy2", chk_busy2, (chk_addr2 != 0) && m_pend[chk_addr2]);
         if (wb_write_enable) begin
            check("no_x0_write", wb_write_addr != 0, 1'b1);
            wlog.push_back('{wb_write_addr, wb_write_data, cyc});
         end
      end
   end

   task automatic idle();
      alu_valid = 0; alu_addr = '0; alu_data = '0;
      mc_valid = 0; mc_addr = '0; mc_data = '0;
      issue_valid = 0; issue_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_alu(input int a, input logic [BW-1:0] d);
      alu_valid = 1; alu_addr = AW'(a); alu_data = d;
   endtask

   task automatic set_mc(input int a, input logic [BW-1:0] d);
      mc_valid = 1; mc_addr = AW'(a); mc_data = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      int k;
      int hits;
      idle();
      chk_addr1 = '0;
      chk_addr2 = '0;

      #1;
      check("rst_we", wb_write_enable, 0);
      check("rst_addr", wb_write_addr, 0);
      check("rst_data", wb_write_data, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", mc_ready, 1);
      #2 rst_n = 1;
      tick();

      // ALU wins the port; the buffered result follows one cycle later.
      wlog.delete();
      c0 = cyc;
      set_alu(5, 64'hAA);
      set_mc(7, 64'hBB);
      tick();
      idle();
      repeat (3) tick();
      check("prio_n", wlog.size(), 2);
      if (wlog.size() >= 2) begin
         check("prio_a0", wlog[0].addr, 5);
         check("prio_d0", wlog[0].data, 64'hAA);
         check("prio_c0", wlog[0].cyc, c0 + 1);
         check("prio_a1", wlog[1].addr, 7);
         check("prio_d1", wlog[1].data, 64'hBB);
         check("prio_c1", wlog[1].cyc, c0 + 2);
      end

      // ALU starves the FIFO until it fills; then entries drain in order.
      wlog.delete();
      k = 0;
      for (int i = 0; i < 14; i++) begin
         idle();
         if (i < 6) set_alu(3, 64'h300 + i);
         if (i == 4) begin
            check("full_ready", mc_ready, 0);
            check("full_count", fifo_count, 4);
         end
         if (k < 5) set_mc(20 + k, 64'h100 + k);
         if (k < 5 && mc_ready) k++;
         tick();
      end
      idle();
      check("full_all_pushed", k, 5);
      check("full_n", wlog.size(), 11);
      if (wlog.size() >= 11) begin
         for (int i = 0; i < 6; i++) begin
            check("full_alu_a", wlog[i].addr, 3);
            check("full_alu_d", wlog[i].data, 64'h300 + i);
         end
         for (int j = 0; j < 5; j++) begin
            check("full_mc_a", wlog[6+j].addr, 20 + j);
            check("full_mc_d", wlog[6+j].data, 64'h100 + j);
            check("full_mc_c", wlog[6+j].cyc, wlog[5].cyc + 1 + j);
         end
      end

      // ALU to x0 yields the port to the FIFO head.
      wlog.delete();
      set_alu(4, 64'h44);
      set_mc(9, 64'h99);
      tick();
      idle();
      set_alu(0, 64'hDEAD);
      tick();
      idle();
      repeat (2) tick();
      check("x0_n", wlog.size(), 2);
      if (wlog.size() >= 2) begin
         check("x0_a0", wlog[0].addr, 4);
         check("x0_a1", wlog[1].addr, 9);
         check("x0_d1", wlog[1].data, 64'h99);
         check("x0_c1", wlog[1].cyc, wlog[0].cyc + 1);
      end
      wlog.delete();
      set_mc(0, 64'h1234);
      tick();
      idle();
      check("x0_mc_count", fifo_count, 0);
      repeat (2) tick();
      check("x0_mc_nowrite", wlog.size(), 0);

      // Scoreboard: busy through the commit cycle, clear afterwards; re-issue wins.
      chk_addr1 = 6'd12;
      chk_addr2 = 6'd0;
      issue_valid = 1; issue_addr = 6'd12;
      tick();
      idle();
      check("sb_busy", chk_busy1, 1);
      check("sb_x0", chk_busy2, 0);
      tick();
      check("sb_busy_hold", chk_busy1, 1);
      set_alu(12, 64'hC12);
      tick();
      idle();
      check("sb_commit_we", wb_write_enable, 1);
      check("sb_commit_addr", wb_write_addr, 12);
      check("sb_busy_commit", chk_busy1, 1);
      tick();
      check("sb_cleared", chk_busy1, 0);
      issue_valid = 1; issue_addr = 6'd12;
      tick();
      idle();
      set_alu(12, 64'hC13);
      tick();
      idle();
      issue_valid = 1; issue_addr = 6'd12;
      tick();
      idle();
      check("sb_reissue", chk_busy1, 1);
      set_alu(12, 64'hC14);
      tick();
      idle();
      tick();
      check("sb_final_clear", chk_busy1, 0);

      // Reset mid-stream with buffered entries and pending registers.
      chk_addr1 = 6'd15;
      chk_addr2 = 6'd16;
      for (int i = 0; i < 3; i++) begin
         idle();
         set_alu(2, 64'h200 + i);
         set_mc(30 + i, 64'h3000 + i);
         if (i == 0) begin issue_valid = 1; issue_addr = 6'd15; end
         if (i == 1) begin issue_valid = 1; issue_addr = 6'd16; end
         if (i < 2) tick();
      end
      @(posedge clk);
      #1;
      check("mrst_pre_count", fifo_count, 3);
      check("mrst_pre_we", wb_write_enable, 1);
      check("mrst_pre_busy", chk_busy1, 1);
      rst_n = 0;
      idle();
      #1;
      check("mrst_we", wb_write_enable, 0);
      check("mrst_addr", wb_write_addr, 0);
      check("mrst_count", fifo_count, 0);
      check("mrst_ready", mc_ready, 1);
      check("mrst_busy1", chk_busy1, 0);
      check("mrst_busy2", chk_busy2, 0);
      #2 rst_n = 1;
      wlog.delete();
      repeat (3) tick();
      check("mrst_nowrite", wlog.size(), 0);

      // Back-to-back alternating ALU / multi-cycle results.
      chk_addr1 = '0;
      chk_addr2 = '0;
      wlog.delete();
      for (int i = 0; i < 8; i++) begin
         idle();
         if (i % 2 == 0) set_alu(40 + i, 64'hB000 + i);
         else            set_mc(40 + i, 64'hB000 + i);
         tick();
      end
      idle();
      repeat (6) tick();
      check("b2b_n", wlog.size(), 8);
      for (int r = 40; r < 48; r++) begin
         hits = 0;
         foreach (wlog[j]) begin
            if (wlog[j].addr == AW'(r) && wlog[j].data == 64'hB000 + (r - 40)) hits++;
         end
         check("b2b_once", hits, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
